// File: rtl/state_recorder.sv
// Shadow copy of write-only NES PPU/APU/palette/OAM state, snooped from the CPU bus and read back by address.
// Optional OAM capture is compiled in with `define STATE_REC_OAM_EN (512x8 RAM instead of 256x8).
module state_recorder #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        m2,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_data_in,
    input  logic        cpu_rw,
    input  logic        freeze,
    input  logic [8:0]  st_rec_addr,
    output logic [7:0]  st_rec_data,
    output logic        ready
);

`ifdef STATE_REC_OAM_EN
    localparam int RAM_AW = 9;
`else
    localparam int RAM_AW = 8;
`endif
    localparam int RAM_DEPTH = 1 << RAM_AW;

    typedef enum logic {S_CLEAR, S_RUN} state_t;
    typedef enum logic [1:0] {RD_ZERO, RD_FLOP, RD_RAM} region_t;

    state_t                  state_q, state_d;
    logic [RAM_AW-1:0]       clr_q, clr_d;
    logic                    ready_q;

    logic [SYNC_STAGES-1:0]  m2_sync_q;
    logic                    m2_prev_q;
    logic                    m2_s;
    logic [15:0]             bus_addr_q;
    logic [7:0]              bus_data_q;
    logic                    bus_rw_q;

    logic [7:0]  ctrl_q, ctrl_d;
    logic [7:0]  mask_q, mask_d;
    logic [7:0]  oamaddr_q, oamaddr_d;
    logic [7:0]  scrollx_q, scrollx_d;
    logic [7:0]  scrolly_q, scrolly_d;
    logic [5:0]  t_hi_q, t_hi_d;
    logic [7:0]  t_lo_q, t_lo_d;
    logic [13:0] v_q, v_d;
    logic        toggle_q, toggle_d;

    logic              cpu_event;
    logic [4:0]        pal_idx;
    logic              ram_we;
    logic [RAM_AW-1:0] ram_waddr;
    logic [7:0]        ram_wdata;
    logic [7:0]        ram_rdata_q;
    logic [7:0]        mem [RAM_DEPTH];

    region_t     region_q, region_d;
    logic [7:0]  flop_rd_q, flop_rd_d;

    assign m2_s      = m2_sync_q[SYNC_STAGES-1];
    assign cpu_event = m2_prev_q & ~m2_s & (state_q == S_RUN) & ~freeze;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m2_sync_q  <= '0;
            m2_prev_q  <= 1'b0;
            bus_addr_q <= '0;
            bus_data_q <= '0;
            bus_rw_q   <= 1'b0;
        end else begin
            m2_sync_q <= {m2_sync_q[SYNC_STAGES-2:0], m2};
            m2_prev_q <= m2_s;
            if (m2_s) begin
                bus_addr_q <= cpu_addr;
                bus_data_q <= cpu_data_in;
                bus_rw_q   <= cpu_rw;
            end
        end
    end

    // Palette mirrors: sprite backdrop entries 0x10/14/18/1C alias the background ones.
    always_comb begin
        pal_idx = v_q[4:0];
        if (pal_idx[4] && (pal_idx[1:0] == 2'b00)) pal_idx[4] = 1'b0;
    end

    // NOTE: every always_comb output gets a default first so no latches are inferred.
    always_comb begin
        state_d   = state_q;
        clr_d     = clr_q;
        ctrl_d    = ctrl_q;
        mask_d    = mask_q;
        oamaddr_d = oamaddr_q;
        scrollx_d = scrollx_q;
        scrolly_d = scrolly_q;
        t_hi_d    = t_hi_q;
        t_lo_d    = t_lo_q;
        v_d       = v_q;
        toggle_d  = toggle_q;
        ram_we    = 1'b0;
        ram_waddr = '0;
        ram_wdata = '0;

        if (state_q == S_CLEAR) begin
            ram_we    = 1'b1;
            ram_waddr = clr_q;
            clr_d     = clr_q + 1'b1;
            if (clr_q == '1) state_d = S_RUN;
        end else if (cpu_event) begin
            if (bus_addr_q[15:13] == 3'b001) begin
                case (bus_addr_q[2:0])
                    3'd0: if (!bus_rw_q) ctrl_d = bus_data_q;
                    3'd1: if (!bus_rw_q) mask_d = bus_data_q;
                    3'd2: if (bus_rw_q) toggle_d = 1'b0;
                    3'd3: if (!bus_rw_q) oamaddr_d = bus_data_q;
                    3'd4: if (!bus_rw_q) begin
                        oamaddr_d = oamaddr_q + 8'd1;
`ifdef STATE_REC_OAM_EN
                        ram_we    = 1'b1;
                        ram_waddr = RAM_AW'({1'b1, oamaddr_q});
                        ram_wdata = bus_data_q;
`endif
                    end
                    3'd5: if (!bus_rw_q) begin
                        if (toggle_q) scrolly_d = bus_data_q;
                        else          scrollx_d = bus_data_q;
                        toggle_d = ~toggle_q;
                    end
                    3'd6: if (!bus_rw_q) begin
                        if (toggle_q) begin
                            t_lo_d = bus_data_q;
                            v_d    = {t_hi_q, bus_data_q};
                        end else begin
                            t_hi_d = bus_data_q[5:0];
                        end
                        toggle_d = ~toggle_q;
                    end
                    default: begin
                        if (!bus_rw_q && (v_q[13:8] == 6'h3F)) begin
                            ram_we    = 1'b1;
                            ram_waddr = RAM_AW'({4'b0010, pal_idx});
                            ram_wdata = bus_data_q;
                        end
                        v_d = v_q + (ctrl_q[2] ? 14'd32 : 14'd1);
                    end
                endcase
            end else if (!bus_rw_q && (bus_addr_q[15:5] == 11'h200) && (bus_addr_q[4:0] <= 5'h17)) begin
                ram_we    = 1'b1;
                ram_waddr = RAM_AW'(9'h010 + {4'b0000, bus_addr_q[4:0]});
                ram_wdata = bus_data_q;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_CLEAR;
            clr_q     <= '0;
            ready_q   <= 1'b0;
            ctrl_q    <= '0;
            mask_q    <= '0;
            oamaddr_q <= '0;
            scrollx_q <= '0;
            scrolly_q <= '0;
            t_hi_q    <= '0;
            t_lo_q    <= '0;
            v_q       <= '0;
            toggle_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_q     <= clr_d;
            ready_q   <= (state_d == S_RUN);
            ctrl_q    <= ctrl_d;
            mask_q    <= mask_d;
            oamaddr_q <= oamaddr_d;
            scrollx_q <= scrollx_d;
            scrolly_q <= scrolly_d;
            t_hi_q    <= t_hi_d;
            t_lo_q    <= t_lo_d;
            v_q       <= v_d;
            toggle_q  <= toggle_d;
        end
    end

    // NOTE: the shadow RAM has no reset; the CLEAR sweep zeroes it after every reset instead.
    always_ff @(posedge clk) begin
        if (ram_we) mem[ram_waddr] <= ram_wdata;
        ram_rdata_q <= mem[st_rec_addr[RAM_AW-1:0]];
    end

    always_comb begin
        region_d  = RD_ZERO;
        flop_rd_d = '0;
        if (st_rec_addr[8:4] == 5'd0) begin
            region_d = RD_FLOP;
            case (st_rec_addr[3:0])
                4'h0:    flop_rd_d = ctrl_q;
                4'h1:    flop_rd_d = mask_q;
                4'h2:    flop_rd_d = oamaddr_q;
                4'h3:    flop_rd_d = scrollx_q;
                4'h4:    flop_rd_d = scrolly_q;
                4'h5:    flop_rd_d = {2'b00, t_hi_q};
                4'h6:    flop_rd_d = t_lo_q;
                4'h7:    flop_rd_d = v_q[7:0];
                4'h8:    flop_rd_d = {2'b00, v_q[13:8]};
                4'h9:    flop_rd_d = {7'd0, toggle_q};
                default: flop_rd_d = '0;
            endcase
        end else if (st_rec_addr <= 9'h027 || st_rec_addr[8:5] == 4'b0010) begin
            region_d = RD_RAM;
`ifdef STATE_REC_OAM_EN
        end else if (st_rec_addr[8]) begin
            region_d = RD_RAM;
`endif
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            region_q  <= RD_ZERO;
            flop_rd_q <= '0;
        end else begin
            region_q  <= region_d;
            flop_rd_q <= flop_rd_d;
        end
    end

    assign st_rec_data = (region_q == RD_FLOP) ? flop_rd_q :
                         (region_q == RD_RAM)  ? ram_rdata_q : 8'h00;
    assign ready       = ready_q;

endmodule
